// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states and
// register-field constants.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the EX-stage load destination
// and the source registers of the instruction in ID.
module hazard_ctrl_load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu_c
);

  // $zero is never a real dependency, so a load targeting it cannot stall.
  always_comb begin
    lu_c = ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch / jump stall-flush control,
// multiply-divide busy window and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic             EX_branch_taken,
  input  logic             ID_jump,
  input  logic             ID_mdu_start,
  input  logic             ID_mdu_read,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_Flush,
  output logic             ID_EX_Flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned BCW = $clog2(MDU_LATENCY + 1);

  state_e           state_q, state_d;
  logic [BCW-1:0]   busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic lu;
  logic md;
  logic stall;
  logic accept;

  hazard_ctrl_load_use_detect u_lu (
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .id_uses_rt  (ID_uses_rt),
    .ex_mem_read (ID_EX_MemRead),
    .ex_rt       (ID_EX_rt),
    .lu_c        (lu)
  );

  always_comb begin
    md     = (state_q == BUSY) && (ID_mdu_start || ID_mdu_read);
    stall  = lu || md;
    accept = ID_mdu_start && !stall && !EX_branch_taken && !reset;
  end

  // Priority mux: reset, taken branch, stall, jump, then free-running.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_Flush    = 1'b0;
    ID_EX_Flush = 1'b0;
    if (reset || EX_branch_taken) begin
      IF_Flush    = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (ID_jump) begin
      IF_Flush    = 1'b1;
    end
  end

  // Busy-window sequencing; a taken branch does not cancel an issued op.
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          state_d    = BUSY;
          busy_cnt_d = BCW'(MDU_LATENCY);
        end
      end
      BUSY: begin
        if (busy_cnt_q == BCW'(1)) begin
          state_d    = RUN;
          busy_cnt_d = '0;
        end else begin
          busy_cnt_d = busy_cnt_q - BCW'(1);
        end
      end
      default: begin
        state_d    = RUN;
        busy_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !EX_branch_taken && !reset && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      busy_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      busy_cnt_q     <= busy_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mdu_busy     = (state_q == BUSY);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl built with MDU_LATENCY=4 and CNT_W=4.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 4;

  logic          clock;
  logic          reset;
  logic [4:0]    ID_rs, ID_rt, ID_EX_rt;
  logic          ID_uses_rt, ID_EX_MemRead, EX_branch_taken, ID_jump;
  logic          ID_mdu_start, ID_mdu_read;
  logic          PC_Write, IF_ID_Write, IF_Flush, ID_EX_Flush, mdu_busy;
  logic [CW-1:0] stall_cycles;
  logic [3:0]    outs;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .ID_rs           (ID_rs),
    .ID_rt           (ID_rt),
    .ID_uses_rt      (ID_uses_rt),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_rt        (ID_EX_rt),
    .EX_branch_taken (EX_branch_taken),
    .ID_jump         (ID_jump),
    .ID_mdu_start    (ID_mdu_start),
    .ID_mdu_read     (ID_mdu_read),
    .PC_Write        (PC_Write),
    .IF_ID_Write     (IF_ID_Write),
    .IF_Flush        (IF_Flush),
    .ID_EX_Flush     (ID_EX_Flush),
    .mdu_busy        (mdu_busy),
    .stall_cycles    (stall_cycles)
  );

  assign outs = {PC_Write, IF_ID_Write, IF_Flush, ID_EX_Flush};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; ID_EX_rt = 5'd0;
    ID_uses_rt = 1'b0; ID_EX_MemRead = 1'b0; EX_branch_taken = 1'b0;
    ID_jump = 1'b0; ID_mdu_start = 1'b0; ID_mdu_read = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    n_cmp++; if (outs !== 4'b1111) begin n_err++; $display("FAIL reset_outs got=%b exp=1111", outs); end
    n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", mdu_busy); end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
    reset = 1'b0;
    #1;
    n_cmp++; if (outs !== 4'b1100) begin n_err++; $display("FAIL idle_outs got=%b exp=1100", outs); end
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; ID_rs = 5'd8;
    #1;
    n_cmp++; if (outs !== 4'b0001) begin n_err++; $display("FAIL lu_rs_outs got=%b exp=0001", outs); end
    step();
    idle();
    #1;
    n_cmp++; if (outs !== 4'b1100) begin n_err++; $display("FAIL lu_clear_outs got=%b exp=1100", outs); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL lu_cnt got=%0d exp=1", stall_cycles); end
    // rt only matters when the ID instruction actually reads it
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd9; ID_rs = 5'd3; ID_rt = 5'd9;
    #1;
    n_cmp++; if (outs !== 4'b1100) begin n_err++; $display("FAIL lu_rt_unused got=%b exp=1100", outs); end
    ID_uses_rt = 1'b1;
    #1;
    n_cmp++; if (outs !== 4'b0001) begin n_err++; $display("FAIL lu_rt_used got=%b exp=0001", outs); end
    step();
    idle();
    n_cmp++; if (stall_cycles !== 4'd2) begin n_err++; $display("FAIL lu_rt_cnt got=%0d exp=2", stall_cycles); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd0; ID_rs = 5'd0; ID_uses_rt = 1'b1;
    #1;
    n_cmp++; if (outs !== 4'b1100) begin n_err++; $display("FAIL zero_outs got=%b exp=1100", outs); end
    step();
    n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL zero_cnt got=%0d exp=0", stall_cycles); end
    idle();
  endtask

  task automatic test_branch_stall();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; ID_rs = 5'd8; EX_branch_taken = 1'b1;
    #1;
    n_cmp++; if (outs !== 4'b1111) begin n_err++; $display("FAIL br_lu_outs got=%b exp=1111", outs); end
    step();
    n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL br_lu_cnt got=%0d exp=0", stall_cycles); end
    idle();
  endtask

  task automatic test_jump_stall();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd5; ID_rs = 5'd5; ID_jump = 1'b1;
    #1;
    n_cmp++; if (outs !== 4'b0001) begin n_err++; $display("FAIL jmp_lu_outs got=%b exp=0001", outs); end
    step();
    ID_EX_MemRead = 1'b0;
    #1;
    n_cmp++; if (outs !== 4'b1110) begin n_err++; $display("FAIL jmp_go_outs got=%b exp=1110", outs); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL jmp_cnt got=%0d exp=1", stall_cycles); end
    step();
    idle();
  endtask

  task automatic test_mdu_window();
    do_reset();
    ID_mdu_start = 1'b1;
    #1;
    n_cmp++; if ({mdu_busy, outs} !== 5'b0_1100) begin n_err++; $display("FAIL mdu_issue got=%b exp=01100", {mdu_busy, outs}); end
    step();
    ID_mdu_start = 1'b0; ID_mdu_read = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_cmp++; if ({mdu_busy, outs} !== 5'b1_0001) begin n_err++; $display("FAIL mdu_busy_c%0d got=%b exp=10001", i, {mdu_busy, outs}); end
      step();
    end
    #1;
    n_cmp++; if ({mdu_busy, outs} !== 5'b0_1100) begin n_err++; $display("FAIL mdu_done got=%b exp=01100", {mdu_busy, outs}); end
    n_cmp++; if (stall_cycles !== 4'd4) begin n_err++; $display("FAIL mdu_cnt got=%0d exp=4", stall_cycles); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ID_mdu_start = 1'b1;
    step();
    ID_mdu_start = 1'b0;
    EX_branch_taken = 1'b1;
    step();
    EX_branch_taken = 1'b0;
    #1;
    n_cmp++; if (mdu_busy !== 1'b1) begin n_err++; $display("FAIL mdu_branch_busy got=%b exp=1", mdu_busy); end
    step();
    step();
    // last BUSY cycle: a new mult/div is held off
    ID_mdu_start = 1'b1;
    #1;
    n_cmp++; if ({mdu_busy, outs} !== 5'b1_0001) begin n_err++; $display("FAIL b2b_last got=%b exp=10001", {mdu_busy, outs}); end
    step();
    #1;
    n_cmp++; if ({mdu_busy, outs} !== 5'b0_1100) begin n_err++; $display("FAIL b2b_accept got=%b exp=01100", {mdu_busy, outs}); end
    step();
    ID_mdu_start = 1'b0;
    #1;
    n_cmp++; if (mdu_busy !== 1'b1) begin n_err++; $display("FAIL b2b_rebusy got=%b exp=1", mdu_busy); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    ID_mdu_start = 1'b1;
    step();
    ID_mdu_start = 1'b0; ID_mdu_read = 1'b1;
    step();
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL rmb_precnt got=%0d exp=1", stall_cycles); end
    reset = 1'b1;
    #1;
    n_cmp++; if (outs !== 4'b1111) begin n_err++; $display("FAIL rmb_outs got=%b exp=1111", outs); end
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if ({mdu_busy, stall_cycles} !== 5'b0_0000) begin n_err++; $display("FAIL rmb_state got=%b exp=00000", {mdu_busy, stall_cycles}); end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd12; ID_rs = 5'd12;
    for (int i = 0; i < 15; i++) step();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_15 got=%0d exp=15", stall_cycles); end
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_20 got=%0d exp=15", stall_cycles); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch_stall();
    test_jump_stall();
    test_mdu_window();
    test_back_to_back();
    test_reset_mid_busy();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
